bram_writer: RTL

- Upstream fill stage for the BRAM that bram_reader drains.
- Accepts a narrow byte stream over a valid/ready handshake and packs it LSB-first into 32-bit words: the first byte lands in bits [7:0], the fourth in [31:24]. bram_reader's serialiser then reproduces the original byte order.
- Writes each completed word to consecutive BRAM addresses through a native BRAM port.
- Supports a partial last word using byte-enable masks, and reports done and full.

---
 rtl/bram_writer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/bram_writer.sv
// Byte-stream to BRAM fill stage: packs input lanes LSB-first into words and
// writes them to consecutive addresses, with byte enables for a short last word.
module bram_writer #(
    parameter int unsigned ADDRESS_WIDTH  = 13,
    parameter int unsigned DATA_IN_WIDTH  = 8,
    parameter int unsigned DATA_OUT_WIDTH = 32,
    parameter int unsigned DEPTH          = 8192
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    input  logic [DATA_IN_WIDTH-1:0]    data_i,
    input  logic                        valid_i,
    input  logic                        last_i,
    output logic                        ready_o,
    output logic [ADDRESS_WIDTH-1:0]    bram_addr,
    output logic                        bram_en,
    output logic [DATA_OUT_WIDTH/8-1:0] bram_we,
    output logic [DATA_OUT_WIDTH-1:0]   bram_data_o,
    output logic                        done_o,
    output logic                        full_o,
    output logic [ADDRESS_WIDTH:0]      word_count_o
);

    localparam int unsigned RATIO     = DATA_OUT_WIDTH / DATA_IN_WIDTH;
    localparam int unsigned LANE_W    = $clog2(RATIO);
    localparam int unsigned BPL       = DATA_IN_WIDTH / 8;
    localparam int unsigned WE_W      = DATA_OUT_WIDTH / 8;
    localparam int unsigned CNT_W     = ADDRESS_WIDTH + 1;
    localparam int unsigned LAST_LANE = RATIO - 1;
    localparam int unsigned LAST_ADDR = DEPTH - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PACK,
        S_WRITE,
        S_DONE,
        S_FULL
    } state_e;

    state_e                    state_q, state_d;
    logic [LANE_W-1:0]         lane_q, lane_d;
    logic [DATA_OUT_WIDTH-1:0] pack_q, pack_d;
    logic                      last_q, last_d;
    logic [ADDRESS_WIDTH-1:0]  addr_q, addr_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic                      full_q, full_d;
    logic                      done_q, done_d;
    logic                      ready_q, ready_d;
    logic                      en_q, en_d;
    logic [WE_W-1:0]           we_q, we_d;
    logic [WE_W-1:0]           mask;
    logic                      accept;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        pack_d  = pack_q;
        last_d  = last_q;
        addr_d  = addr_q;
        count_d = count_q;
        full_d  = full_q;
        mask    = '0;
        accept  = valid_i && ready_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_PACK;
                    lane_d  = '0;
                    pack_d  = '0;
                    last_d  = 1'b0;
                    addr_d  = '0;
                    count_d = '0;
                    full_d  = 1'b0;
                end
            end
            S_PACK: begin
                if (start_i) begin
                    lane_d  = '0;
                    pack_d  = '0;
                    last_d  = 1'b0;
                    addr_d  = '0;
                    count_d = '0;
                    full_d  = 1'b0;
                end else if (accept) begin
                    for (int unsigned i = 0; i < RATIO; i++) begin
                        if (lane_q == LANE_W'(i)) begin
                            pack_d[i*DATA_IN_WIDTH +: DATA_IN_WIDTH] = data_i;
                        end
                        if (LANE_W'(i) <= lane_q) begin
                            mask[i*BPL +: BPL] = '1;
                        end
                    end
                    lane_d = LANE_W'(lane_q + LANE_W'(1));
                    if (lane_q == LANE_W'(LAST_LANE) || last_i) begin
                        state_d = S_WRITE;
                        last_d  = last_i;
                    end
                end
            end
            S_WRITE: begin
                addr_d  = ADDRESS_WIDTH'(addr_q + ADDRESS_WIDTH'(1));
                count_d = CNT_W'(count_q + CNT_W'(1));
                lane_d  = '0;
                pack_d  = '0;
                last_d  = 1'b0;
                // A restart during the write lets the write finish, then clears the frame.
                if (start_i) begin
                    state_d = S_PACK;
                    addr_d  = '0;
                    count_d = '0;
                    full_d  = 1'b0;
                end else if (addr_q == ADDRESS_WIDTH'(LAST_ADDR)) begin
                    state_d = S_FULL;
                    full_d  = 1'b1;
                end else if (last_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_PACK;
                end
            end
            S_DONE, S_FULL: begin
                if (start_i) begin
                    state_d = S_PACK;
                    lane_d  = '0;
                    pack_d  = '0;
                    last_d  = 1'b0;
                    addr_d  = '0;
                    count_d = '0;
                    full_d  = 1'b0;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_PACK);
        en_d    = (state_d == S_WRITE);
        we_d    = (state_d == S_WRITE) ? mask : '0;
        done_d  = (state_d == S_DONE) ||
                  (state_q == S_WRITE && state_d == S_FULL && last_q);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            lane_q  <= '0;
            pack_q  <= '0;
            last_q  <= 1'b0;
            addr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
            en_q    <= 1'b0;
            we_q    <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            pack_q  <= pack_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            full_q  <= full_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            en_q    <= en_d;
            we_q    <= we_d;
        end
    end

    assign ready_o      = ready_q;
    assign bram_addr    = addr_q;
    assign bram_en      = en_q;
    assign bram_we      = we_q;
    assign bram_data_o  = pack_q;
    assign done_o       = done_q;
    assign full_o       = full_q;
    assign word_count_o = count_q;

endmodule
